// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Purpose : Shared definitions for the byte-addressed data memory / LSU.
//           RV32I load/store funct3 codes, the LSU state encoding and the
//           datapath width.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int XLEN = 32;

    // RV32I load/store funct3 codes. funct3[1:0] is the access size
    // (0=byte, 1=half, 2=word); funct3[2] marks the unsigned loads.
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_lsu_if.sv
`default_nettype none
// ============================================================================
// Module  : dmem_lsu_if
// Purpose : Request/response handshake bundle between the core and dmem_lsu.
// Ports   : master - core side (drives req_*, resp_ready)
//           slave  - LSU side  (drives req_ready, resp_*)
// Revision: 1.0 - initial release
// ============================================================================
interface dmem_lsu_if;
    import dmem_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_align
// Purpose : Combinational byte-lane logic for RV32I loads and stores.
// Ports   : funct3_i   - load/store funct3
//           addr_i     - byte lane (addr[1:0])
//           wdata_i    - store data (rs2)
//           word_i     - current memory word at the addressed index
//           be_o       - byte enables for the access
//           wword_o    - word to write back (selected lanes replaced)
//           rdata_o    - sign/zero-extended load result
//           misalign_o - access not naturally aligned
// Revision: 1.0 - initial release
// ============================================================================
module lsu_align
    import dmem_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] word_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wword_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] wrep;     // store data replicated across all lanes
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    always_comb begin
        be_o       = 4'b0000;
        wrep       = wdata_i;
        misalign_o = 1'b0;
        case (funct3_i[1:0])
            2'd0: begin
                be_o = 4'b0001 << addr_i;
                wrep = {4{wdata_i[7:0]}};
            end
            2'd1: begin
                be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
                wrep       = {2{wdata_i[15:0]}};
                misalign_o = addr_i[0];
            end
            2'd2: begin
                be_o       = 4'b1111;
                misalign_o = (addr_i != 2'b00);
            end
            default: be_o = 4'b0000;
        endcase
    end

    // Replication lets each lane pick from the same bit positions of wrep.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign wword_o[8*i +: 8] = be_o[i] ? wrep[8*i +: 8] : word_i[8*i +: 8];
    end

    assign byte_sel = 8'(word_i >> {addr_i, 3'b000});
    assign half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        rdata_o = '0;
        case (funct3_i)
            F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_o = {24'd0, byte_sel};
            F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_o = {16'd0, half_sel};
            F3_W:    rdata_o = word_i;
            default: rdata_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module  : dmem_lsu
// Purpose : Byte-addressed data memory with RV32I load/store unit,
//           configurable access latency and valid/ready handshakes.
// Ports   : clk - clock, rst - synchronous active-high reset
//           bus - dmem_lsu_if.slave (req_* in, req_ready out,
//                 resp_valid/resp_rdata/resp_err out, resp_ready in)
// Revision: 1.0 - initial release
// ============================================================================
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int LATENCY     = 1
) (
    input  logic       clk,
    input  logic       rst,
    dmem_lsu_if.slave  bus
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            latch_en;
    logic            commit;

    // Request latch: the access uses these, never the live bus inputs.
    logic            write_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;

    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic [XLEN-1:0] mem_q [0:DEPTH_WORDS-1];

    logic [AW-1:0]   idx;
    logic [XLEN-1:0] word;
    logic [3:0]      be;
    logic [XLEN-1:0] wword;
    logic [XLEN-1:0] ld_data;
    logic            misalign;
    logic            out_of_range;
    logic            illegal;
    logic            err;

    assign idx          = addr_q[AW+1:2];
    assign word         = mem_q[idx];
    assign out_of_range = (addr_q[XLEN-1:AW+2] != '0);
    assign illegal      = write_q ? (funct3_q > F3_W)
                                  : ((funct3_q == 3'd3) || (funct3_q >= 3'd6));
    assign err          = misalign | out_of_range | illegal;

    lsu_align u_align (
        .funct3_i   (funct3_q),
        .addr_i     (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .word_i     (word),
        .be_o       (be),
        .wword_o    (wword),
        .rdata_o    (ld_data),
        .misalign_o (misalign)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    latch_en = 1'b1;
                    cnt_d    = CNT_INIT;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                write_q  <= bus.req_write;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
            end
            if (commit) begin
                rdata_q <= (write_q || err) ? '0 : ld_data;
                err_q   <= err;
            end
        end
    end

    // The array has no reset; gating on rst makes reset win over a
    // coincident commit edge.
    always_ff @(posedge clk) begin
        if (!rst && commit && write_q && !err && (be != 4'b0000)) begin
            mem_q[idx] <= wword;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_lsu
// Purpose : Self-checking bench for dmem_lsu. Three instances with different
//           depth/latency share one driver; a byte-array reference model
//           predicts every response.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;
    import dmem_pkg::*;

    localparam int NDUT       = 3;
    localparam int DEP [NDUT] = '{512, 16, 512};
    localparam int LAT [NDUT] = '{1, 4, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int          sel = 0;
    logic        t_req_valid  = 1'b0;
    logic        t_write      = 1'b0;
    logic [2:0]  t_f3         = 3'd0;
    logic [31:0] t_addr       = '0;
    logic [31:0] t_wdata      = '0;
    logic        t_resp_ready = 1'b0;

    dmem_lsu_if b0 ();
    dmem_lsu_if b1 ();
    dmem_lsu_if b2 ();

    assign b0.req_valid = t_req_valid && (sel == 0);
    assign b1.req_valid = t_req_valid && (sel == 1);
    assign b2.req_valid = t_req_valid && (sel == 2);
    assign b0.resp_ready = t_resp_ready && (sel == 0);
    assign b1.resp_ready = t_resp_ready && (sel == 1);
    assign b2.resp_ready = t_resp_ready && (sel == 2);
    assign b0.req_write = t_write;  assign b1.req_write = t_write;  assign b2.req_write = t_write;
    assign b0.req_funct3 = t_f3;    assign b1.req_funct3 = t_f3;    assign b2.req_funct3 = t_f3;
    assign b0.req_addr = t_addr;    assign b1.req_addr = t_addr;    assign b2.req_addr = t_addr;
    assign b0.req_wdata = t_wdata;  assign b1.req_wdata = t_wdata;  assign b2.req_wdata = t_wdata;

    dmem_lsu #(.DEPTH_WORDS(512), .LATENCY(1)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
    dmem_lsu #(.DEPTH_WORDS(16),  .LATENCY(4)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    dmem_lsu #(.DEPTH_WORDS(512), .LATENCY(3)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

    logic        w_req_ready, w_resp_valid, w_err;
    logic [31:0] w_rdata;
    always_comb begin
        w_req_ready  = b0.req_ready;
        w_resp_valid = b0.resp_valid;
        w_rdata      = b0.resp_rdata;
        w_err        = b0.resp_err;
        if (sel == 1) begin
            w_req_ready  = b1.req_ready;
            w_resp_valid = b1.resp_valid;
            w_rdata      = b1.resp_rdata;
            w_err        = b1.resp_err;
        end else if (sel == 2) begin
            w_req_ready  = b2.req_ready;
            w_resp_valid = b2.resp_valid;
            w_rdata      = b2.resp_rdata;
            w_err        = b2.resp_err;
        end
    end

    // Reference memory: plain bytes, one array per instance.
    logic [7:0] mb [NDUT][2048];

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s dut=%0d got=%08h exp=%08h t=%0t", tag, sel, got, exp, $time);
        end
    endtask

    // Byte-level reference: an access of 2**funct3[1:0] bytes at a.
    task automatic model(input int d, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
        int          nb;
        logic [31:0] v;
        nb = 1 << f3[1:0];
        er = 1'b0;
        rd = '0;
        if (wr && f3 > 3'd2) er = 1'b1;
        if (!wr && (f3 == 3'd3 || f3 >= 3'd6)) er = 1'b1;
        if ((a % nb) != 0) er = 1'b1;
        if (longint'(a) >= longint'(DEP[d]) * 4) er = 1'b1;
        if (!er) begin
            if (wr) begin
                for (int i = 0; i < nb; i++) mb[d][int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[d][int'(a) + i];
                if (f3 < 3'd4 && nb < 4 && v[8*nb-1]) begin
                    for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
                end
                rd = v;
            end
        end
    endtask

    task automatic do_op(input int d, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int stall,
                         output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          n;
        model(d, wr, f3, a, wd, exp_rd, exp_er);
        @(negedge clk);
        sel = d;
        #1;
        check_eq("idle_req_ready", 32'(w_req_ready), 32'd1);
        t_req_valid = 1'b1; t_write = wr; t_f3 = f3; t_addr = a; t_wdata = wd;
        t_resp_ready = 1'b0;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        while (!w_resp_valid && n < 40) begin
            check_eq("busy_req_ready", 32'(w_req_ready), 32'd0);
            // Junk on the request bus outside IDLE must be ignored.
            t_req_valid = 1'($urandom);
            t_write     = 1'($urandom);
            t_f3        = 3'($urandom);
            t_addr      = $urandom;
            t_wdata     = $urandom;
            @(negedge clk);
            n++;
        end
        check_eq("resp_latency", 32'(n), 32'(LAT[d] + 1));
        check_eq("resp_rdata", w_rdata, exp_rd);
        check_eq("resp_err", 32'(w_err), 32'(exp_er));
        rd = w_rdata;
        er = w_err;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(w_resp_valid), 32'd1);
            check_eq("stall_rdata", w_rdata, rd);
            check_eq("stall_req_ready", 32'(w_req_ready), 32'd0);
        end
        // Offer a load together with resp_ready: it must not be taken.
        t_resp_ready = 1'b1;
        t_req_valid = 1'b1; t_write = 1'b0; t_f3 = F3_W; t_addr = '0;
        @(posedge clk);
        @(negedge clk);
        check_eq("release_valid", 32'(w_resp_valid), 32'd0);
        check_eq("release_idle", 32'(w_req_ready), 32'd1);
        t_req_valid  = 1'b0;
        t_resp_ready = 1'b0;
    endtask

    // Accept a store, then assert reset on the following edge.
    task automatic store_then_reset(input int d, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        sel = d;
        t_req_valid = 1'b1; t_write = 1'b1; t_f3 = F3_W; t_addr = a; t_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        t_req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_req_ready", 32'(w_req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(w_resp_valid), 32'd0);
        check_eq("rst_rdata", w_rdata, 32'd0);
        check_eq("rst_err", 32'(w_err), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        int          r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            sel = d;
            #1;
            check_eq("reset_req_ready", 32'(w_req_ready), 32'd1);
            check_eq("reset_resp_valid", 32'(w_resp_valid), 32'd0);
            check_eq("reset_rdata", w_rdata, 32'd0);
            check_eq("reset_err", 32'(w_err), 32'd0);
        end

        // Fill the first 16 words of every instance with known data.
        for (int d = 0; d < NDUT; d++)
            for (int w = 0; w < 16; w++)
                do_op(d, 1'b1, F3_W, 32'(w * 4), $urandom, 0, rd, er);

        // Word store/load round trip on the single-cycle instance.
        do_op(0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 0, rd, er);
        check_eq("sw_rdata_zero", rd, 32'd0);
        do_op(0, 1'b0, F3_W, 32'h10, 32'h0, 0, rd, er);
        check_eq("lw_deadbeef", rd, 32'hDEADBEEF);
        check_eq("lw_deadbeef_err", 32'(er), 32'd0);

        // Byte store into lane 1, then signed/unsigned byte loads.
        do_op(0, 1'b1, F3_B, 32'h11, 32'h000000AA, 0, rd, er);
        do_op(0, 1'b0, F3_W, 32'h10, 32'h0, 0, rd, er);
        check_eq("lw_after_sb", rd, 32'hDEADAAEF);
        do_op(0, 1'b0, F3_B, 32'h11, 32'h0, 0, rd, er);
        check_eq("lb_sext", rd, 32'hFFFFFFAA);
        do_op(0, 1'b0, F3_BU, 32'h11, 32'h0, 0, rd, er);
        check_eq("lbu_zext", rd, 32'h000000AA);

        // Upper halfword store and loads, plus a misaligned halfword.
        do_op(0, 1'b1, F3_H, 32'h12, 32'h00008001, 0, rd, er);
        do_op(0, 1'b0, F3_H, 32'h12, 32'h0, 0, rd, er);
        check_eq("lh_sext", rd, 32'hFFFF8001);
        do_op(0, 1'b0, F3_HU, 32'h12, 32'h0, 0, rd, er);
        check_eq("lhu_zext", rd, 32'h00008001);
        do_op(0, 1'b0, F3_H, 32'h13, 32'h0, 0, rd, er);
        check_eq("lh_misaligned_err", 32'(er), 32'd1);

        // Faulting accesses: misaligned word store, out of range, bad funct3.
        do_op(0, 1'b1, F3_W, 32'h22, 32'h55555555, 0, rd, er);
        check_eq("sw_misaligned_err", 32'(er), 32'd1);
        do_op(0, 1'b0, F3_W, 32'h20, 32'h0, 0, rd, er);
        do_op(0, 1'b0, F3_W, 32'h800, 32'h0, 0, rd, er);
        check_eq("lw_oor_err", 32'(er), 32'd1);
        do_op(0, 1'b0, 3'd3, 32'h20, 32'h0, 0, rd, er);
        check_eq("ld_f3_3_err", 32'(er), 32'd1);
        do_op(0, 1'b1, 3'd4, 32'h20, 32'hFFFFFFFF, 0, rd, er);
        check_eq("st_f3_4_err", 32'(er), 32'd1);

        // Depth-16 instance: last valid word and first invalid address.
        do_op(1, 1'b1, F3_W, 32'h3C, 32'hA5A5_0F0F, 0, rd, er);
        do_op(1, 1'b0, F3_W, 32'h3C, 32'h0, 3, rd, er);
        check_eq("lw_last_word", rd, 32'hA5A5_0F0F);
        do_op(1, 1'b1, F3_B, 32'h40, 32'h0000_0011, 2, rd, er);
        check_eq("sb_oor_err", 32'(er), 32'd1);

        // Reset one cycle after accept drops the store (latency 3).
        do_op(2, 1'b1, F3_W, 32'h30, 32'hCAFEF00D, 0, rd, er);
        store_then_reset(2, 32'h30, 32'h12345678);
        do_op(2, 1'b0, F3_W, 32'h30, 32'h0, 0, rd, er);
        check_eq("lw_after_rst_drop", rd, 32'hCAFEF00D);

        // Reset on the commit edge itself (latency 1): no write either.
        store_then_reset(0, 32'h14, 32'h87654321);
        do_op(0, 1'b0, F3_W, 32'h14, 32'h0, 0, rd, er);

        // Randomized traffic on all instances.
        for (int k = 0; k < 180; k++) begin
            int d;
            d = k % NDUT;
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'(DEP[d] * 4) + 32'($urandom_range(0, 255));
            else if (r == 1) a = $urandom | 32'h8000_0000;
            else             a = 32'($urandom_range(0, 63));
            do_op(d, 1'($urandom), 3'($urandom), a, $urandom,
                  int'($urandom_range(0, 3)), rd, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
